// File: rtl/datamemory_arb_pkg.sv
// Shared definitions for the DataMemory arbiter slice.
//   - state_t   : arbiter FSM encoding (IDLE / ISSUE / WAIT)
//   - DEF_*     : default address/data widths of DataMemory
//   - REQ0/REQ1 : requester identifiers used for grant index and ownership
package datamemory_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   valid[1:0]  in   pending requests (bit n = requester n)
//   last_grant  in   requester that won most recently (pointer kept by parent)
//   enable      in   when low, no grant is issued
//   grant[1:0]  out  one-hot grant, zero when disabled or nothing valid
//   grant_idx   out  index of the winner (meaningful only when grant != 0)
module rr_arbiter2
  import datamemory_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = REQ0;
    grant     = 2'b00;
    // On contention the requester that did not win last time goes first;
    // otherwise the single valid requester wins.
    if (valid == 2'b11) begin
      grant_idx = ~last_grant;
    end else if (valid[1]) begin
      grant_idx = REQ1;
    end
    if (enable && (valid != 2'b00)) begin
      grant = (grant_idx == REQ1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/datamemory_arbiter.sv
// Shares a single-port DataMemory between two requesters.
//
// Handshake: a requester raises i_ReqValidN with a stable payload
// (write flag, address, write data) and holds it until it sees o_ReqReadyN
// high at a rising edge; that edge is the accept. Ready is combinational and
// only offered in IDLE to the round-robin winner. Read data comes back later
// as a one-cycle o_RespValidN pulse with o_RespDataN; writes get no response.
//
// Ports:
//   i_clk, i_rst                      clock, async active-high reset
//   i_ReqValidN/WriteN/AddressN/WriteDataN  request from requester N
//   o_ReqReadyN                       request accepted this cycle
//   o_RespValidN, o_RespDataN         read response to requester N
//   o_MemAddress/WriteData/WriteEn/ReadEn, i_MemReadData  DataMemory side
//   o_Busy                            FSM is not in IDLE
module datamemory_arbiter
  import datamemory_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ReqValid0,
  input  logic                  i_ReqValid1,
  input  logic                  i_ReqWrite0,
  input  logic                  i_ReqWrite1,
  input  logic [ADDR_WIDTH-1:0] i_ReqAddress0,
  input  logic [ADDR_WIDTH-1:0] i_ReqAddress1,
  input  logic [DATA_WIDTH-1:0] i_ReqWriteData0,
  input  logic [DATA_WIDTH-1:0] i_ReqWriteData1,
  output logic                  o_ReqReady0,
  output logic                  o_ReqReady1,
  output logic                  o_RespValid0,
  output logic                  o_RespValid1,
  output logic [DATA_WIDTH-1:0] o_RespData0,
  output logic [DATA_WIDTH-1:0] o_RespData1,
  output logic [ADDR_WIDTH-1:0] o_MemAddress,
  output logic [DATA_WIDTH-1:0] o_MemWriteData,
  output logic                  o_MemWriteEn,
  output logic                  o_MemReadEn,
  input  logic [DATA_WIDTH-1:0] i_MemReadData,
  output logic                  o_Busy
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_t           state_q, state_d;
  logic             owner_q;
  logic             write_q;
  logic             last_grant_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]       grant;
  logic             grant_idx;
  logic             accept;
  logic             sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic             resp_fire;

  // Reset gates the enable so ready drops the moment reset is asserted,
  // even though the FSM already sits in IDLE.
  rr_arbiter2 u_arb (
    .valid      ({i_ReqValid1, i_ReqValid0}),
    .last_grant (last_grant_q),
    .enable     ((state_q == IDLE) && !i_rst),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign o_ReqReady0 = grant[0];
  assign o_ReqReady1 = grant[1];
  assign accept      = |grant;
  assign o_Busy      = (state_q != IDLE);

  assign sel_write = (grant_idx == REQ1) ? i_ReqWrite1     : i_ReqWrite0;
  assign sel_addr  = (grant_idx == REQ1) ? i_ReqAddress1   : i_ReqAddress0;
  assign sel_wdata = (grant_idx == REQ1) ? i_ReqWriteData1 : i_ReqWriteData0;

  // Last WAIT cycle: memory data is valid now and is captured at this edge.
  assign resp_fire = (state_q == WAIT) && (cnt_q == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = write_q ? IDLE : WAIT;
      WAIT:    if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_q        <= REQ0;
      write_q        <= 1'b0;
      last_grant_q   <= REQ1;
      cnt_q          <= '0;
      o_MemAddress   <= '0;
      o_MemWriteData <= '0;
      o_MemWriteEn   <= 1'b0;
      o_MemReadEn    <= 1'b0;
      o_RespValid0   <= 1'b0;
      o_RespValid1   <= 1'b0;
      o_RespData0    <= '0;
      o_RespData1    <= '0;
    end else begin
      // Strobes are registered from the accept, so they are high exactly
      // during the single ISSUE cycle.
      o_MemWriteEn <= accept & sel_write;
      o_MemReadEn  <= accept & ~sel_write;

      if (accept) begin
        owner_q        <= grant_idx;
        write_q        <= sel_write;
        last_grant_q   <= grant_idx;
        o_MemAddress   <= sel_addr;
        o_MemWriteData <= sel_wdata;
      end

      if ((state_q == ISSUE) && !write_q) begin
        cnt_q <= CNT_W'(READ_LATENCY - 1);
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end

      o_RespValid0 <= resp_fire && (owner_q == REQ0);
      o_RespValid1 <= resp_fire && (owner_q == REQ1);
      if (resp_fire && (owner_q == REQ0)) o_RespData0 <= i_MemReadData;
      if (resp_fire && (owner_q == REQ1)) o_RespData1 <= i_MemReadData;
    end
  end

endmodule

// File: tb/tb_datamemory_arbiter.sv
// Directed bench for datamemory_arbiter with a behavioural DataMemory model.
module tb_datamemory_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid0 = 1'b0, req_valid1 = 1'b0;
  logic       req_write0 = 1'b0, req_write1 = 1'b0;
  logic [9:0] req_addr0 = '0, req_addr1 = '0;
  logic [7:0] req_wdata0 = '0, req_wdata1 = '0;
  logic       req_ready0, req_ready1;
  logic       resp_valid0, resp_valid1;
  logic [7:0] resp_data0, resp_data1;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we, mem_re;
  logic [7:0] mem_rdata;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] ref_data [0:1023];

  datamemory_arbiter dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_ReqValid0     (req_valid0),
    .i_ReqValid1     (req_valid1),
    .i_ReqWrite0     (req_write0),
    .i_ReqWrite1     (req_write1),
    .i_ReqAddress0   (req_addr0),
    .i_ReqAddress1   (req_addr1),
    .i_ReqWriteData0 (req_wdata0),
    .i_ReqWriteData1 (req_wdata1),
    .o_ReqReady0     (req_ready0),
    .o_ReqReady1     (req_ready1),
    .o_RespValid0    (resp_valid0),
    .o_RespValid1    (resp_valid1),
    .o_RespData0     (resp_data0),
    .o_RespData1     (resp_data1),
    .o_MemAddress    (mem_addr),
    .o_MemWriteData  (mem_wdata),
    .o_MemWriteEn    (mem_we),
    .o_MemReadEn     (mem_re),
    .i_MemReadData   (mem_rdata),
    .o_Busy          (busy)
  );

  // DataMemory model: one-cycle synchronous read, synchronous write.
  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit r);
    return r ? req_ready1 : req_ready0;
  endfunction

  task automatic drive(input bit r, input logic v, input logic w,
                       input logic [9:0] a, input logic [7:0] d);
    if (!r) begin
      req_valid0 = v; req_write0 = w; req_addr0 = a; req_wdata0 = d;
    end else begin
      req_valid1 = v; req_write1 = w; req_addr1 = a; req_wdata1 = d;
    end
  endtask

  // Waits (bounded) for ready, lets the accepting edge pass, drops valid.
  task automatic wait_accept(input bit r);
    int n = 0;
    #1;
    while (!rdy(r) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check(r ? "accept1" : "accept0", {31'd0, rdy(r)}, 32'd1);
    @(posedge clk); #1;
    if (!r) req_valid0 = 1'b0; else req_valid1 = 1'b0;
  endtask

  task automatic do_write(input bit r, input logic [9:0] a, input logic [7:0] d);
    drive(r, 1'b1, 1'b1, a, d);
    wait_accept(r);
    @(negedge clk);
    check("wr_we",    mem_we, 1);
    check("wr_re",    mem_re, 0);
    check("wr_addr",  mem_addr, a);
    check("wr_data",  mem_wdata, d);
    check("wr_busy",  busy, 1);
    @(negedge clk);
    check("wr_we_off", mem_we, 0);
    check("wr_idle",   busy, 0);
  endtask

  task automatic do_read(input bit r, input logic [9:0] a, input logic [7:0] e);
    drive(r, 1'b1, 1'b0, a, 8'h00);
    if (!r) exp_q0.push_back(e); else exp_q1.push_back(e);
    wait_accept(r);
    @(negedge clk);
    check("rd_re",   mem_re, 1);
    check("rd_we",   mem_we, 0);
    check("rd_addr", mem_addr, a);
    @(negedge clk);
    check("rd_wait_re",   mem_re, 0);
    check("rd_wait_resp", r ? resp_valid1 : resp_valid0, 0);
    check("rd_wait_busy", busy, 1);
    @(negedge clk);
    check("rd_resp",       r ? resp_valid1 : resp_valid0, 1);
    check("rd_resp_other", r ? resp_valid0 : resp_valid1, 0);
    check("rd_data",       r ? resp_data1 : resp_data0, e);
    check("rd_idle",       busy, 0);
  endtask

  // ---------------- scoreboard / invariants ----------------
  always @(negedge clk) begin
    check("strobe_overlap", {31'd0, mem_we & mem_re}, 0);
    check("resp_overlap",   {31'd0, resp_valid0 & resp_valid1}, 0);
    if (resp_valid0) begin
      check("resp0_expected", {31'd0, exp_q0.size() > 0}, 1);
      if (exp_q0.size() > 0) check("sb_data0", resp_data0, exp_q0.pop_front());
    end
    if (resp_valid1) begin
      check("resp1_expected", {31'd0, exp_q1.size() > 0}, 1);
      if (exp_q1.size() > 0) check("sb_data1", resp_data1, exp_q1.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int g, n, c0, c1;
    int gseq [4];

    // 1: reset values, first request accepted immediately
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {req_ready0, req_ready1, resp_valid0, resp_valid1, mem_we, mem_re, busy}, 0);
    check("rst_data", {resp_data0, resp_data1, mem_wdata}, 0);
    check("rst_addr", mem_addr, 0);
    rst = 1'b0;
    drive(0, 1'b1, 1'b1, 10'h005, 8'hA5);
    #1;
    check("t1_ready0", req_ready0, 1);
    check("t1_ready1", req_ready1, 0);

    // 2: write then read back on requester 0
    do_write(0, 10'h005, 8'hA5);
    do_read(0, 10'h005, 8'hA5);
    @(negedge clk);
    check("t2_pulse_end", resp_valid0, 0);
    check("t2_data_hold", resp_data0, 8'hA5);
    do_write(0, 10'h3FF, 8'h5A);

    // 3: continuous contention from reset: grants alternate 0,1,0,1
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 10'h3FF, 8'h00);
    drive(1, 1'b1, 1'b1, 10'h3FF, 8'h3C);
    exp_q0.push_back(8'h5A);
    exp_q0.push_back(8'h3C);
    @(negedge clk); #1;
    check("t3_rst_ready", {req_ready0, req_ready1}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    g = 0; n = 0; c0 = 0; c1 = 0;
    gseq = '{-1, -1, -1, -1};
    while (g < 4 && n < 40) begin
      @(negedge clk);
      check("t3_one_ready", {31'd0, req_ready0 & req_ready1}, 0);
      if (req_ready0) begin gseq[g] = 0; g++; c0++; end
      else if (req_ready1) begin gseq[g] = 1; g++; c1++; end
      @(posedge clk); #1;
      if (c0 == 2) req_valid0 = 1'b0;
      if (c1 == 2) req_valid1 = 1'b0;
      n++;
    end
    check("t3_grants", g, 4);
    check("t3_g0", gseq[0], 0);
    check("t3_g1", gseq[1], 1);
    check("t3_g2", gseq[2], 0);
    check("t3_g3", gseq[3], 1);
    repeat (5) @(negedge clk);
    check("t3_idle", busy, 0);
    check("t3_q0_drained", exp_q0.size(), 0);

    // 4: top address, cross-requester data
    do_write(1, 10'h3FF, 8'h77);
    do_read(0, 10'h3FF, 8'h77);

    // 5: reset during WAIT kills the read; pointer returns to favour req0
    drive(0, 1'b1, 1'b0, 10'h005, 8'h00);
    wait_accept(0);
    @(negedge clk);
    check("t5_issue_re", mem_re, 1);
    @(negedge clk);
    check("t5_wait_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_strobes", {mem_we, mem_re}, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_resp", {resp_valid0, resp_valid1}, 0);
    repeat (2) begin
      @(negedge clk);
      check("t5_no_resp", {resp_valid0, resp_valid1}, 0);
    end
    rst = 1'b0;
    drive(0, 1'b1, 1'b1, 10'h010, 8'h11);
    drive(1, 1'b1, 1'b1, 10'h020, 8'h22);
    #1;
    check("t5_ready0", req_ready0, 1);
    check("t5_ready1", req_ready1, 0);
    wait_accept(0);
    wait_accept(1);
    @(negedge clk);
    check("t5_w1_we", mem_we, 1);
    check("t5_w1_addr", mem_addr, 10'h020);
    repeat (2) @(negedge clk);

    // 6: full sweep, writes alternate requesters, reads via the other one
    for (int i = 0; i < 1024; i++) begin
      ref_data[i] = 8'($urandom_range(0, 255));
      do_write(i[0], i[9:0], ref_data[i]);
    end
    for (int i = 0; i < 1024; i++) begin
      do_read(!i[0], i[9:0], ref_data[i]);
    end
    repeat (3) @(negedge clk);
    check("t6_q0_drained", exp_q0.size(), 0);
    check("t6_q1_drained", exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datamemory_arbiter.md
Name: datamemory_arbiter

Overview:
Shares the single-port DataMemory (10-bit address, 8-bit data, separate write/read enables) between two requesters, for example a CPU load/store unit and a DMA/loader.
Each requester uses a valid/ready request handshake and receives read data on a one-cycle response pulse.
A round-robin arbiter picks the winner, and an FSM sequences the memory strobes.
The block sits directly in front of DataMemory; DataMemory ports connect 1:1 to the o_Mem*/i_Mem* ports.

Parameters:
ADDR_WIDTH, 10, memory address width (1024 locations)
DATA_WIDTH, 8, data width
READ_LATENCY, 1, rising edges from DataMemory sampling i_ReadEn until o_ReadData is valid; must be >= 1

Ports:
i_clk  in  1  clock; all state changes on rising edge
i_rst  in  1  reset; asynchronous, active-high
i_ReqValid0 / i_ReqValid1  in  1  request pending on requester 0 / 1
i_ReqWrite0 / i_ReqWrite1  in  1  1 = write, 0 = read
i_ReqAddress0 / i_ReqAddress1  in  ADDR_WIDTH  request address
i_ReqWriteData0 / i_ReqWriteData1  in  DATA_WIDTH  write data
o_ReqReady0 / o_ReqReady1  out  1  request accepted this cycle (combinational)
o_RespValid0 / o_RespValid1  out  1  one-cycle pulse; read data valid
o_RespData0 / o_RespData1  out  DATA_WIDTH  read data, valid while matching RespValid is high
o_MemAddress  out  ADDR_WIDTH  to DataMemory i_Address
o_MemWriteData  out  DATA_WIDTH  to DataMemory i_WriteData
o_MemWriteEn  out  1  to DataMemory i_WriteEn
o_MemReadEn  out  1  to DataMemory i_ReadEn
i_MemReadData  in  DATA_WIDTH  from DataMemory o_ReadData
o_Busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset values: every output 0, FSM in IDLE, round-robin pointer last_grant = 1, so requester 0 wins the first contention.
- A request is accepted when ReqValid & ReqReady are both high at a rising edge.
- Requesters hold valid and payload stable until accepted.
- FSM IDLE:
  - Ready is asserted only in IDLE, and only to the arbitration winner.
  - If one requester is valid, it wins.
  - If both are valid, the one that is not last_grant wins.
  - On accept: latch owner, write flag, address and data; update last_grant := owner; go to ISSUE.
  - With no valid request, stay in IDLE and keep ready low.
- FSM ISSUE, one cycle:
  - o_MemWriteEn = write flag and o_MemReadEn = !write flag; both are registered.
  - o_MemAddress and o_MemWriteData show the latched request.
  - A write completes at the edge ending ISSUE and goes to IDLE; no response is generated.
  - A read goes to WAIT and loads the counter with READ_LATENCY-1.
- FSM WAIT:
  - Both strobes are low; address is held.
  - Counter decrements each cycle.
  - At the edge where counter==0, register i_MemReadData into the owner's RespData, set the owner's RespValid for exactly one cycle, and go to IDLE.
- Timing, READ_LATENCY=1:
  - Read accepted at edge t: ISSUE in cycle t+1, WAIT in cycle t+2, RespValid high in cycle t+3.
  - Write occupies 2 cycles; read occupies 2+READ_LATENCY cycles.
  - A new request can be accepted in the same IDLE cycle that RespValid is high.
- Invariants:
  - o_MemWriteEn and o_MemReadEn are never both high.
  - At most one of RespValid0/1 is high in any cycle.
  - The non-owner's RespData holds its previous value.
- Memory outputs o_MemAddress/o_MemWriteData keep their last value in IDLE; strobes are 0.
- Addresses use the full range 0..2^ADDR_WIDTH-1 with no wrap or remap; 0x3FF is legal.
- Request arrival during ISSUE/WAIT: no ready; the request waits.
- Reset mid-operation:
  - Strobes, RespValid and ready drop immediately (asynchronously) and the FSM returns to IDLE.
  - The in-flight read produces no response; an in-flight write may or may not have landed.
  - last_grant returns to 1.

Decomposition:
- Shared package datamemory_arb_pkg holds:
  - state encoding IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2;
  - default ADDR_WIDTH/DATA_WIDTH;
  - requester ID constants REQ0=1'b0, REQ1=1'b1.
- Sub-module rr_arbiter2 takes (valid[1:0], last_grant, enable) and returns one-hot grant plus grant index. It is purely combinational; the pointer register lives in the parent.

Test Plan:
1. Hold i_rst high, then release. All outputs are 0 and o_Busy=0. Drive i_ReqValid0 at the first edge; ReqReady0 is high that cycle.
2. Req0 writes 0xA5 to address 0x005. Ready0 is high one cycle; o_MemWriteEn is high exactly one cycle with address 0x005 and data 0xA5. Req0 then reads 0x005; o_MemReadEn is high one cycle, and RespValid0=1 with RespData0=0xA5 three cycles after accept. RespValid1 stays 0.
3. Both requesters valid continuously from reset (req0 reads, req1 writes 0x3C to 0x3FF). Grants alternate 0,1,0,1. The first grant is 0. The strobes never overlap.
4. Req1 writes 0x77 to 0x3FF, then req0 reads 0x3FF. o_MemAddress=0x3FF and RespData0=0x77, confirming the top address with no wrap.
5. Assert i_rst during WAIT of a read. Strobes and Busy are 0 immediately and no RespValid pulse appears. After release, simultaneous requests grant req0 first.
6. Write random bytes to all 1024 addresses, alternating requesters, then read all of them back through the opposite requester. A scoreboard matches every RespData with no mismatches and no missing or duplicate responses.
